rr_ring_arbiter: RTL and testbench

RR_RING_ARBITER -- requirements
Module: rr_ring_arbiter

---
 rtl/rr_ring_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_ring_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_ring_arbiter.sv
// Four-requester round-robin arbiter with a one-hot priority ring, per-owner hold limit
// and an optional idle gap between consecutive grants. All outputs are registered.
module rr_ring_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Req,
  output logic [3:0] Grant,
  output logic [1:0] Owner,
  output logic       Busy,
  output logic       Timeout,
  output logic [3:0] Ptr
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);
  localparam logic [1:0] GAP_C      = 2'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] grant_nxt, ptr_nxt;
  logic [1:0] owner_nxt;
  logic       busy_nxt, timeout_nxt;
  logic [3:0] hold, hold_nxt;
  logic [1:0] gap, gap_nxt;
  logic [1:0] ptr_idx, win_idx, cand;
  logic       win_found;

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  assign ptr_idx = onehot_idx(Ptr);

  // Ring search: first set request starting at the pointer position, wrapping 3 -> 0.
  always_comb begin
    win_idx   = 2'd0;
    win_found = 1'b0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_idx + 2'(k);
      if (!win_found && Req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = Grant;
    owner_nxt   = Owner;
    busy_nxt    = Busy;
    timeout_nxt = 1'b0;
    ptr_nxt     = Ptr;
    hold_nxt    = hold;
    gap_nxt     = gap;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt = 4'b0001 << win_idx;
          owner_nxt = win_idx;
          busy_nxt  = 1'b1;
          hold_nxt  = 4'd1;
          state_nxt = OWNED;
        end
      end
      OWNED: begin
        // A dropped request wins over the hold limit, so a release on the limit edge stays voluntary.
        if (!Req[Owner] || hold == MAX_HOLD_C) begin
          grant_nxt   = 4'b0000;
          busy_nxt    = 1'b0;
          ptr_nxt     = rotl1(Grant);
          hold_nxt    = 4'd0;
          timeout_nxt = Req[Owner];
          if (GAP_C != 2'd0) begin
            state_nxt = GAP;
            gap_nxt   = 2'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          hold_nxt = hold + 4'd1;
        end
      end
      GAP: begin
        if (gap == GAP_C) state_nxt = IDLE;
        else              gap_nxt   = gap + 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      Grant   <= 4'b0000;
      Owner   <= 2'd0;
      Busy    <= 1'b0;
      Timeout <= 1'b0;
      Ptr     <= 4'b0001;
      hold    <= 4'd0;
      gap     <= 2'd0;
    end else begin
      state   <= state_nxt;
      Grant   <= grant_nxt;
      Owner   <= owner_nxt;
      Busy    <= busy_nxt;
      Timeout <= timeout_nxt;
      Ptr     <= ptr_nxt;
      hold    <= hold_nxt;
      gap     <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Bench for rr_ring_arbiter: two instances (default and MAX_HOLD=3/GAP_CYCLES=0) share stimulus,
// checked every cycle against an integer-level model plus directed literal expectations.
module tb_rr_ring_arbiter;

  localparam int MH [2] = '{8, 3};
  localparam int GP [2] = '{1, 0};

  logic       Clock;
  logic       Reset;
  logic [3:0] Req;
  logic [3:0] gnt [2];
  logic [1:0] own [2];
  logic       bsy [2];
  logic       tmo [2];
  logic [3:0] ptr [2];

  int n_tests = 0;
  int n_fail  = 0;

  rr_ring_arbiter #(.MAX_HOLD(8), .GAP_CYCLES(1)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .Grant(gnt[0]), .Owner(own[0]), .Busy(bsy[0]), .Timeout(tmo[0]), .Ptr(ptr[0])
  );

  rr_ring_arbiter #(.MAX_HOLD(3), .GAP_CYCLES(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .Grant(gnt[1]), .Owner(own[1]), .Busy(bsy[1]), .Timeout(tmo[1]), .Ptr(ptr[1])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Model: owner index (-1 = none), cycles held, ring position, cooldown cycles left.
  int m_owner [2];
  int m_held  [2];
  int m_pos   [2];
  int m_cool  [2];
  int m_to    [2];
  bit armed = 1'b0;

  function automatic int first_from(input int pos, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(pos + k) % 4]) return (pos + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_owner[i] = -1; m_held[i] = 0; m_pos[i] = 0; m_cool[i] = 0; m_to[i] = 0;
      end else if (armed) begin
        m_to[i] = 0;
        if (m_owner[i] >= 0) begin
          if (!Req[m_owner[i]] || m_held[i] == MH[i]) begin
            m_to[i]    = Req[m_owner[i]] ? 1 : 0;
            m_pos[i]   = (m_owner[i] + 1) % 4;
            m_owner[i] = -1;
            m_cool[i]  = GP[i];
          end else begin
            m_held[i]++;
          end
        end else if (m_cool[i] > 0) begin
          m_cool[i]--;
        end else begin
          m_owner[i] = first_from(m_pos[i], Req);
          m_held[i]  = 1;
        end
      end
    end
    if (Reset) armed = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d_grant", i), 32'(gnt[i]),
              m_owner[i] >= 0 ? 32'(1) << m_owner[i] : 32'd0);
        check($sformatf("m%0d_busy", i), 32'(bsy[i]), 32'(m_owner[i] >= 0));
        check($sformatf("m%0d_timeout", i), 32'(tmo[i]), 32'(m_to[i]));
        check($sformatf("m%0d_ptr", i), 32'(ptr[i]), 32'(1) << m_pos[i]);
        if (m_owner[i] >= 0) check($sformatf("m%0d_owner", i), 32'(own[i]), 32'(m_owner[i]));
      end
    end
  end

  // Inputs change 2 time units after a rising edge, so each call sets what the next n edges sample.
  task automatic apply(input logic [3:0] r, input logic rs, input int n);
    Req   = r;
    Reset = rs;
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  initial begin
    Req = 4'b0000;
    Reset = 1'b1;
    apply(4'b0000, 1'b1, 2);
    check("rst_grant", 32'(gnt[0]), 32'h0);
    check("rst_ptr", 32'(ptr[0]), 32'h1);

    // Single requester, voluntary release (dut0 releases on its hold-limit edge: still voluntary).
    apply(4'b0100, 1'b0, 1);
    check("a_grant", 32'(gnt[0]), 32'h4);
    check("a_owner", 32'(own[0]), 32'd2);
    apply(4'b0100, 1'b0, 2);
    apply(4'b0000, 1'b0, 1);
    check("a_rel_grant", 32'(gnt[0]), 32'h0);
    check("a_rel_ptr", 32'(ptr[0]), 32'h8);
    check("a_rel_to", 32'(tmo[0]), 32'h0);
    check("a_rel_to_lim", 32'(tmo[1]), 32'h0);
    apply(4'b0000, 1'b0, 3);

    // Move pointer to 0100, then wrap search.
    apply(4'b0010, 1'b0, 1);
    apply(4'b0000, 1'b0, 3);
    check("b_ptr", 32'(ptr[0]), 32'h4);
    apply(4'b0011, 1'b0, 1);
    check("b_wrap_grant", 32'(gnt[0]), 32'h1);
    apply(4'b0000, 1'b0, 1);
    check("b_rel_ptr", 32'(ptr[0]), 32'h2);
    apply(4'b0000, 1'b0, 3);

    // Owner 1 held while requester 3 toggles.
    apply(4'b0010, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      apply((k % 2 == 0) ? 4'b1010 : 4'b0010, 1'b0, 1);
      check("c_hold_grant", 32'(gnt[0]), 32'h2);
    end
    apply(4'b1000, 1'b0, 1);
    check("c_rel_grant", 32'(gnt[0]), 32'h0);
    check("c_rel_ptr", 32'(ptr[0]), 32'h4);
    apply(4'b0000, 1'b0, 3);

    // Reset mid-grant, then full rotation under all-high requests.
    apply(4'b1000, 1'b0, 1);
    check("e_grant", 32'(gnt[0]), 32'h8);
    apply(4'b1111, 1'b1, 1);
    check("e_rst_grant", 32'(gnt[0]), 32'h0);
    check("e_rst_busy", 32'(bsy[0]), 32'h0);
    check("e_rst_ptr", 32'(ptr[0]), 32'h1);
    apply(4'b1111, 1'b0, 1);
    check("e_resume", 32'(gnt[0]), 32'h1);
    for (int i = 0; i < 45; i++) begin
      check("d_rot_grant", 32'(gnt[0]), (i % 10) < 8 ? 32'(1) << ((i / 10) % 4) : 32'h0);
      check("d_rot_to", 32'(tmo[0]), 32'((i % 10) == 8));
      apply(4'b1111, 1'b0, 1);
    end

    // Zero-gap handover on dut0, then a forced release.
    apply(4'b0000, 1'b1, 1);
    apply(4'b0100, 1'b0, 2);
    apply(4'b0001, 1'b0, 1);
    check("f_low_g0", 32'(gnt[1]), 32'h0);
    check("f_low_g", 32'(gnt[0]), 32'h0);
    apply(4'b0001, 1'b0, 1);
    check("f_next_g0", 32'(gnt[1]), 32'h1);
    check("f_gap_g", 32'(gnt[0]), 32'h0);
    apply(4'b0001, 1'b0, 1);
    check("f_next_g", 32'(gnt[0]), 32'h1);
    apply(4'b0001, 1'b0, 1);
    apply(4'b0001, 1'b0, 1);
    check("f_force_g0", 32'(gnt[1]), 32'h0);
    check("f_force_to0", 32'(tmo[1]), 32'h1);
    apply(4'b0000, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
